// File: rtl/intersection_scheduler_if.sv
// Lamp and request bundle for the intersection scheduler.
// master drives requests and observes lamps; slave is the scheduler side.
interface intersection_scheduler_if;
  logic       req_ns;
  logic       req_ew;
  logic       ped_req;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output req_ns, req_ew, ped_req,
    input  ns_red, ns_yellow, ns_green,
    input  ew_red, ew_yellow, ew_green,
    input  walk, phase
  );

  modport slave (
    input  req_ns, req_ew, ped_req,
    output ns_red, ns_yellow, ns_green,
    output ew_red, ew_yellow, ew_green,
    output walk, phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-road traffic light scheduler with min/max green and clearance.
// Define PED_PHASE_EN to enable the pedestrian walk phase.
module intersection_scheduler #(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  intersection_scheduler_if.slave   bus
);

  localparam logic [2:0] S_ALL_RED   = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_EW_GREEN  = 3'd3;
  localparam logic [2:0] S_EW_YELLOW = 3'd4;
  localparam logic [2:0] S_PED_WALK  = 3'd5;

  localparam logic [15:0] L_GMIN = 16'(GREEN_MIN);
  localparam logic [15:0] L_GMAX = 16'(GREEN_MAX);
  localparam logic [15:0] L_YEL  = 16'(YELLOW_TIME);
  localparam logic [15:0] L_AR   = 16'(ALLRED_TIME);
  localparam logic [15:0] L_WALK = 16'(WALK_TIME);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_timer;
  logic [15:0] w_dwell;
  logic        r_pend_ns;
  logic        r_pend_ew;
  logic        r_grant_ew;
  logic        w_ped_pend;
  logic [2:0]  w_grant_green;
  logic        w_change;

  // w_dwell counts cycles spent in the state including this one
  assign w_dwell       = r_timer + 16'd1;
  assign w_change      = (w_next != r_state);
  assign w_grant_green = r_grant_ew ? S_EW_GREEN : S_NS_GREEN;

`ifdef PED_PHASE_EN
  logic r_pend_ped;

  assign w_ped_pend = r_pend_ped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_ped <= 1'b0;
    end else if (w_change && w_next == S_PED_WALK) begin
      r_pend_ped <= 1'b0;
    end else if (bus.ped_req) begin
      r_pend_ped <= 1'b1;
    end
  end
`else
  assign w_ped_pend = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ALL_RED: begin
        if (w_dwell >= L_AR) begin
          w_next = w_ped_pend ? S_PED_WALK : w_grant_green;
        end
      end
      S_NS_GREEN: begin
        if ((r_pend_ew || w_ped_pend) &&
            ((w_dwell >= L_GMIN && !bus.req_ns) ||
             w_dwell >= L_GMAX)) begin
          w_next = S_NS_YELLOW;
        end
      end
      S_NS_YELLOW: begin
        if (w_dwell >= L_YEL) w_next = S_ALL_RED;
      end
      S_EW_GREEN: begin
        if ((r_pend_ns || w_ped_pend) &&
            ((w_dwell >= L_GMIN && !bus.req_ew) ||
             w_dwell >= L_GMAX)) begin
          w_next = S_EW_YELLOW;
        end
      end
      S_EW_YELLOW: begin
        if (w_dwell >= L_YEL) w_next = S_ALL_RED;
      end
      S_PED_WALK: begin
        if (w_dwell >= L_WALK) w_next = w_grant_green;
      end
      default: w_next = S_ALL_RED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ALL_RED;
      r_timer <= 16'd0;
    end else begin
      r_state <= w_next;
      r_timer <= w_change ? 16'd0 : w_dwell;
    end
  end

  // Entering its own green clears a road's request, even if set now
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_ns  <= 1'b0;
      r_pend_ew  <= 1'b0;
      r_grant_ew <= 1'b0;
    end else begin
      if (w_change && w_next == S_NS_GREEN) begin
        r_pend_ns <= 1'b0;
      end else if (bus.req_ns) begin
        r_pend_ns <= 1'b1;
      end
      if (w_change && w_next == S_EW_GREEN) begin
        r_pend_ew <= 1'b0;
      end else if (bus.req_ew) begin
        r_pend_ew <= 1'b1;
      end
      if (r_state == S_NS_YELLOW && w_change) begin
        r_grant_ew <= 1'b1;
      end else if (r_state == S_EW_YELLOW && w_change) begin
        r_grant_ew <= 1'b0;
      end
    end
  end

  logic [6:0] w_lamps;

  always_comb begin
    w_lamps = 7'b100_100_0;
    case (r_state)
      S_NS_GREEN:  w_lamps = 7'b001_100_0;
      S_NS_YELLOW: w_lamps = 7'b010_100_0;
      S_EW_GREEN:  w_lamps = 7'b100_001_0;
      S_EW_YELLOW: w_lamps = 7'b100_010_0;
`ifdef PED_PHASE_EN
      S_PED_WALK:  w_lamps = 7'b100_100_1;
`endif
      default:     w_lamps = 7'b100_100_0;
    endcase
  end

  assign bus.ns_red    = w_lamps[6];
  assign bus.ns_yellow = w_lamps[5];
  assign bus.ns_green  = w_lamps[4];
  assign bus.ew_red    = w_lamps[3];
  assign bus.ew_yellow = w_lamps[2];
  assign bus.ew_green  = w_lamps[1];
  assign bus.walk      = w_lamps[0];
  assign bus.phase     = r_state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized and directed bench for intersection_scheduler.
// Lamps are compared each cycle against a cycle-count reference model.
module tb_intersection_scheduler;

  localparam int GMIN  = 4;
  localparam int GMAX  = 10;
  localparam int YEL   = 2;
  localparam int ALLR  = 1;
  localparam int WALKT = 3;
`ifdef PED_PHASE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int M_AR   = 0;
  localparam int M_NSG  = 1;
  localparam int M_NSY  = 2;
  localparam int M_EWG  = 3;
  localparam int M_EWY  = 4;
  localparam int M_WALK = 5;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;

  intersection_scheduler_if bus ();

  intersection_scheduler #(
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_TIME(YEL),
    .ALLRED_TIME(ALLR),
    .WALK_TIME  (WALKT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int m_st;
  int m_cnt;
  bit m_pns;
  bit m_pew;
  bit m_pped;
  bit m_gew;

  function automatic void model_reset();
    m_st   = M_AR;
    m_cnt  = 0;
    m_pns  = 1'b0;
    m_pew  = 1'b0;
    m_pped = 1'b0;
    m_gew  = 1'b0;
  endfunction

  function automatic void model_step(bit rn, bit re, bit rp);
    int n;
    int nxt;
    bit ped;
    n   = m_cnt + 1;
    nxt = m_st;
    ped = PED_EN && m_pped;
    case (m_st)
      M_AR:
        if (n >= ALLR)
          nxt = ped ? M_WALK : (m_gew ? M_EWG : M_NSG);
      M_NSG:
        if ((m_pew || ped) &&
            ((n >= GMIN && !rn) || n >= GMAX))
          nxt = M_NSY;
      M_NSY:
        if (n >= YEL) begin
          nxt   = M_AR;
          m_gew = 1'b1;
        end
      M_EWG:
        if ((m_pns || ped) &&
            ((n >= GMIN && !re) || n >= GMAX))
          nxt = M_EWY;
      M_EWY:
        if (n >= YEL) begin
          nxt   = M_AR;
          m_gew = 1'b0;
        end
      M_WALK:
        if (n >= WALKT) nxt = m_gew ? M_EWG : M_NSG;
      default: nxt = M_AR;
    endcase
    m_pns  = m_pns | rn;
    m_pew  = m_pew | re;
    m_pped = m_pped | (PED_EN & rp);
    if (nxt != m_st) begin
      if (nxt == M_NSG)  m_pns  = 1'b0;
      if (nxt == M_EWG)  m_pew  = 1'b0;
      if (nxt == M_WALK) m_pped = 1'b0;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_st = nxt;
  endfunction

  function automatic logic [6:0] exp_lamps(int st);
    case (st)
      M_NSG:   return 7'b001_100_0;
      M_NSY:   return 7'b010_100_0;
      M_EWG:   return 7'b100_001_0;
      M_EWY:   return 7'b100_010_0;
      M_WALK:  return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [6:0] lamps_now();
    return {bus.ns_red, bus.ns_yellow, bus.ns_green,
            bus.ew_red, bus.ew_yellow, bus.ew_green,
            bus.walk};
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(bus.req_ns, bus.req_ew, bus.ped_req);
    #1;
    chk("lamps", 32'(lamps_now()), 32'(exp_lamps(m_st)));
    chk("ns_onehot",
        $countones({bus.ns_red, bus.ns_yellow, bus.ns_green}), 1);
    chk("ew_onehot",
        $countones({bus.ew_red, bus.ew_yellow, bus.ew_green}), 1);
    chk("one_road", 32'(!bus.ns_red && !bus.ew_red), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async", 32'(lamps_now()), 32'(7'b100_100_0));
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    chk("rel_allred", 32'(lamps_now()), 32'(7'b100_100_0));
  endtask

  // Counts consecutive cycles showing the current lamp pattern
  task automatic count_run(output int n);
    logic [6:0] v;
    v = lamps_now();
    n = 1;
    for (int k = 0; k < 300; k++) begin
      cyc();
      bus.req_ew  = 1'b0;
      bus.ped_req = 1'b0;
      if (lamps_now() !== v) return;
      n++;
    end
    chk("run_timeout", 1, 0);
  endtask

  int n;

  initial begin
    bus.req_ns  = 1'b0;
    bus.req_ew  = 1'b0;
    bus.ped_req = 1'b0;
    model_reset();

    do_reset();
    repeat (60) cyc();
    chk("rest_ns_green", bus.ns_green, 1);
    chk("rest_ew_red", bus.ew_red, 1);

    do_reset();
    cyc();
    bus.req_ew = 1'b1;
    count_run(n);
    chk("min_green_len", n, GMIN);
    chk("yellow_seen", bus.ns_yellow, 1);
    count_run(n);
    chk("yellow_len", n, YEL);
    count_run(n);
    chk("allred_len", n, ALLR);
    chk("ew_green_on", bus.ew_green, 1);

    reset_n = 1'b0;
    #1;
    chk("midrst_lamps", 32'(lamps_now()), 32'(7'b100_100_0));
    model_reset();
    cyc();
    reset_n = 1'b1;
    #1;
    chk("midrst_allred", 32'(lamps_now()), 32'(7'b100_100_0));
    cyc();
    chk("midrst_ns_green", bus.ns_green, 1);

    do_reset();
    cyc();
    bus.req_ns = 1'b1;
    bus.req_ew = 1'b1;
    count_run(n);
    chk("max_green_len", n, GMAX);
    chk("max_then_yellow", bus.ns_yellow, 1);
    bus.req_ns = 1'b0;
    repeat (5) cyc();

`ifdef PED_PHASE_EN
    do_reset();
    cyc();
    bus.ped_req = 1'b1;
    count_run(n);
    chk("ped_green_len", n, GMIN);
    count_run(n);
    chk("ped_yellow_len", n, YEL);
    count_run(n);
    chk("ped_allred_len", n, ALLR);
    chk("walk_lamps", 32'(lamps_now()), 32'(7'b100_100_1));
    count_run(n);
    chk("walk_len", n, WALKT);
    chk("ped_then_ew", bus.ew_green, 1);
`else
    do_reset();
    cyc();
    for (int i = 0; i < 8; i++) begin
      bus.ped_req = 1'b1;
      cyc();
      bus.ped_req = 1'b0;
      repeat (4) cyc();
      chk("noped_walk", bus.walk, 0);
      chk("noped_ns_green", bus.ns_green, 1);
    end
`endif

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.req_ns  = ($urandom_range(0, 99) < 12);
      bus.req_ew  = ($urandom_range(0, 99) < 12);
      bus.ped_req = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
